// File: rtl/fp16_pkg.sv
// Shared fp16 constants and operand classification type.
package fp16_pkg;
    localparam int unsigned FP16_BIAS        = 15;
    localparam int unsigned FP16_EXP_W       = 5;
    localparam int unsigned FP16_MANT_W      = 10;
    localparam logic [4:0]  FP16_EXP_SPECIAL = 5'h1F;
    localparam logic [15:0] INT16_MAX        = 16'h7FFF;
    localparam logic [15:0] INT16_MIN        = 16'h8000;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp16_class_t;
endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 decode: sign, class, exponent and mantissa with hidden bit.
// Denormals flush to ZERO.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]            a,
    output logic                   sign,
    output fp16_class_t            cls,
    output logic [FP16_EXP_W-1:0]  exp,
    output logic [FP16_MANT_W:0]   mant
);
    logic [FP16_MANT_W-1:0] frac;

    always_comb begin
        sign = a[15];
        exp  = a[14:10];
        frac = a[9:0];
        mant = '0;
        if (exp == '0) begin
            cls = ZERO;
        end else if (exp == FP16_EXP_SPECIAL) begin
            cls = (frac != '0) ? NAN : INF;
        end else begin
            cls  = NORMAL;
            mant = {1'b1, frac};
        end
    end
endmodule

// File: rtl/fp16toint.sv
// fp16 -> int16 converter, two-stage valid/ready pipeline.
// Define FP16TOINT_RNE_EN for round-to-nearest-even; default truncates toward zero.
module fp16toint
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [15:0] i_a,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_res,
    output logic [2:0]  o_flags
);
    // exponent at which {1,mant} sits unshifted in a 16.11 fixed-point word
    localparam logic [4:0] SH_REF = 5'(FP16_BIAS - 1);

    logic        en1, en2;
    logic        s1_valid, s2_valid;
    logic        c_sign;
    fp16_class_t c_cls;
    logic [4:0]  c_exp;
    logic [10:0] c_mant;
    logic [26:0] m_ext, s1_fx_d;
    logic [4:0]  sh;
    logic        s1_sticky_d;

    logic        s1_sign, s1_sticky;
    fp16_class_t s1_cls;
    logic [26:0] s1_fx;

    logic [15:0] int_mag;
    logic [10:0] frac;
    logic        inexact;
    logic [16:0] mag;
    logic [15:0] res_d;
    logic [2:0]  flags_d;

    assign en2         = !s2_valid || i_out_ready;
    assign en1         = !s1_valid || en2;
    assign o_in_ready  = en1;
    assign o_out_valid = s2_valid;

    fp16_classify u_classify (
        .a    (i_a),
        .sign (c_sign),
        .cls  (c_cls),
        .exp  (c_exp),
        .mant (c_mant)
    );

    // S1: align into 16 integer + 11 fraction bits; bits below the fraction fold into sticky
    always_comb begin
        m_ext       = {16'b0, c_mant};
        s1_fx_d     = '0;
        s1_sticky_d = 1'b0;
        sh          = '0;
        if (c_exp >= SH_REF) begin
            s1_fx_d = m_ext << (c_exp - SH_REF);
        end else begin
            sh          = SH_REF - c_exp;
            s1_fx_d     = m_ext >> sh;
            s1_sticky_d = |(c_mant & ((11'd1 << sh) - 11'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (en1) begin
            s1_valid <= i_in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en1 && i_in_valid) begin
            s1_sign   <= c_sign;
            s1_cls    <= c_cls;
            s1_fx     <= s1_fx_d;
            s1_sticky <= s1_sticky_d;
        end
    end

    // S2: round, apply sign, saturate
    always_comb begin
        int_mag = s1_fx[26:11];
        frac    = s1_fx[10:0];
        inexact = (|frac) || s1_sticky;
`ifdef FP16TOINT_RNE_EN
        mag = {1'b0, int_mag} + 17'(frac[10] && ((|frac[9:0]) || s1_sticky || int_mag[0]));
`else
        mag = {1'b0, int_mag};
`endif
        res_d   = '0;
        flags_d = '0;
        unique case (s1_cls)
            ZERO: ;
            NAN: begin
                res_d   = INT16_MIN;
                flags_d = 3'b100;
            end
            INF: begin
                res_d   = s1_sign ? INT16_MIN : INT16_MAX;
                flags_d = 3'b010;
            end
            default: begin
                if (!s1_sign && mag > 17'd32767) begin
                    res_d   = INT16_MAX;
                    flags_d = 3'b010;
                end else if (s1_sign && mag > 17'd32768) begin
                    res_d   = INT16_MIN;
                    flags_d = 3'b010;
                end else begin
                    res_d   = s1_sign ? (~mag[15:0] + 16'd1) : mag[15:0];
                    flags_d = {2'b00, inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            o_res    <= '0;
            o_flags  <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_res   <= res_d;
                o_flags <= flags_d;
            end
        end
    end
endmodule

// File: tb/tb_fp16toint.sv
// Randomized self-checking bench for fp16toint against a real-arithmetic reference model.
module tb_fp16toint;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [15:0] i_a = '0;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [15:0] o_res;
    logic [2:0]  o_flags;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [18:0] q[$];
    logic [15:0] seen[$];
    logic        rand_rdy = 1'b0;
    logic        rdy_val = 1'b1;
    logic        stall_prev = 1'b0;
    logic [18:0] held = '0;

    initial i_out_ready = 1'b1;

    fp16toint dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_res       (o_res),
        .o_flags     (o_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        i_out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value = (-1)^s * (1024+m) * 2^(e-25), rounded then range-checked
    function automatic logic [18:0] model(input logic [15:0] a);
        int  e = int'(a[14:10]);
        int  m = int'(a[9:0]);
        real mg, ip, fr, v;
        bit  inx;
        if (e == 0) return {16'h0000, 3'b000};
        if (e == 31) begin
            if (m != 0) return {16'h8000, 3'b100};
            return a[15] ? {16'h8000, 3'b010} : {16'h7FFF, 3'b010};
        end
        mg = 1024.0 + m;
        for (int k = e; k > 25; k--) mg = mg * 2.0;
        for (int k = e; k < 25; k++) mg = mg / 2.0;
        ip  = $floor(mg);
        fr  = mg - ip;
        inx = (fr != 0.0);
`ifdef FP16TOINT_RNE_EN
        if (fr > 0.5 || (fr == 0.5 && $floor(ip / 2.0) * 2.0 != ip)) ip = ip + 1.0;
`endif
        v = a[15] ? -ip : ip;
        if (v > 32767.0)  return {16'h7FFF, 3'b010};
        if (v < -32768.0) return {16'h8000, 3'b010};
        return {16'($rtoi(v)), 2'b00, inx};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(o_out_valid), 32'd1);
                check("hold_data", 32'({o_res, o_flags}), 32'(held));
            end
            if (o_out_valid && i_out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'({o_res, o_flags}), 32'h7FFFFFFF);
                end else begin
                    check("stream", 32'({o_res, o_flags}), 32'(q.pop_front()));
                end
                seen.push_back(o_res);
            end
            if (i_in_valid && o_in_ready) q.push_back(model(i_a));
            stall_prev = o_out_valid && !i_out_ready;
            held = {o_res, o_flags};
        end
    end

    task automatic send(input logic [15:0] a);
        logic ok;
        int   n = 0;
        i_in_valid = 1'b1;
        i_a = a;
        do begin
            @(negedge clk);
            ok = o_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 500);
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || o_out_valid) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] er, input logic [2:0] ef);
        rand_rdy = 1'b0;
        rdy_val = 1'b1;
        drain();
        i_a = a;
        i_in_valid = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        check("lat_edge1", 32'(o_out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_edge2", 32'(o_out_valid), 32'd1);
        check("lit_res", 32'(o_res), 32'(er));
        check("lit_flags", 32'(o_flags), 32'(ef));
    endtask

    initial begin
        #3;
        check("rst_valid", 32'(o_out_valid), 32'd0);
        check("rst_res", 32'(o_res), 32'd0);
        check("rst_flags", 32'(o_flags), 32'd0);
        check("rst_ready", 32'(o_in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #2;

        run_one(16'h3C00, 16'h0001, 3'b000);
        run_one(16'hC500, 16'hFFFB, 3'b000);
`ifdef FP16TOINT_RNE_EN
        run_one(16'h3E00, 16'h0002, 3'b001);
        run_one(16'h4100, 16'h0002, 3'b001);
        run_one(16'h4300, 16'h0004, 3'b001);
`else
        run_one(16'h3E00, 16'h0001, 3'b001);
        run_one(16'h4100, 16'h0002, 3'b001);
        run_one(16'h4300, 16'h0003, 3'b001);
`endif
        run_one(16'h7800, 16'h7FFF, 3'b010);
        run_one(16'hF800, 16'h8000, 3'b000);
        run_one(16'h7C00, 16'h7FFF, 3'b010);
        run_one(16'hFC00, 16'h8000, 3'b010);
        run_one(16'h7E00, 16'h8000, 3'b100);
        run_one(16'h0001, 16'h0000, 3'b000);
        run_one(16'h8000, 16'h0000, 3'b000);
        run_one(16'h3400, 16'h0000, 3'b001);

        // backpressure: two transfers fill the pipe, third waits
        rdy_val = 1'b0;
        @(posedge clk);
        #2;
        seen.delete();
        send(16'h3C00);
        send(16'h4000);
        i_a = 16'h4200;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(o_in_ready), 32'd0);
            check("bp_hold_res", 32'(o_res), 32'h0001);
        end
        rdy_val = 1'b1;
        send(16'h4200);
        i_in_valid = 1'b0;
        drain();
        check("bp_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("bp_order0", 32'(seen[0]), 32'h0001);
            check("bp_order1", 32'(seen[1]), 32'h0002);
            check("bp_order2", 32'(seen[2]), 32'h0003);
        end

        // reset with two operands in flight
        rdy_val = 1'b0;
        @(posedge clk);
        #2;
        send(16'h4000);
        send(16'h4200);
        i_in_valid = 1'b0;
        check("pre_rst_valid", 32'(o_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_out_valid), 32'd0);
        check("mid_rst_res", 32'(o_res), 32'd0);
        check("mid_rst_flags", 32'(o_flags), 32'd0);
        check("mid_rst_ready", 32'(o_in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rdy_val = 1'b1;
        run_one(16'h4400, 16'h0004, 3'b000);

        // randomized stream with random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 0) a[14:10] = 5'($urandom_range(10, 31));
            if ($urandom_range(0, 3) == 0) begin
                i_in_valid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                send(a);
            end
        end
        i_in_valid = 1'b0;
        rand_rdy = 1'b0;
        rdy_val = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp16toint.md
FP16TOINT -- requirements
Module: fp16toint

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 i_in_valid  in  1  input operand valid.
REQ-005 o_in_ready  out  1  block can accept an operand this cycle.
REQ-006 i_a  in  16  fp16 operand: sign[15], exp[14:10], mant[9:0].
REQ-007 o_out_valid  out  1  result valid.
REQ-008 i_out_ready  in  1  downstream accepts the result this cycle.
REQ-009 o_res  out  16  signed two's-complement int16 result.
REQ-010 o_flags  out  3  {invalid, overflow, inexact}, aligned with o_res.

Function
REQ-011 Input transfer occurs when i_in_valid && o_in_ready; output transfer occurs when o_out_valid && i_out_ready.
REQ-012 Two-stage pipeline: S1 decodes, classifies and shifts; S2 rounds, negates, saturates and registers o_res/o_flags.
REQ-013 Latency is 2 cycles from the input transfer edge to o_out_valid, with no stall.
REQ-014 Throughput is 1 result per cycle while i_out_ready=1.
REQ-015 Stall rules: en2 = !s2_valid || i_out_ready; en1 = !s1_valid || en2; o_in_ready = en1.
REQ-016 o_res and o_flags hold stable while o_out_valid && !i_out_ready.
REQ-017 Results leave in input order; none are dropped or duplicated.
REQ-018 DAZ: exp==0 gives result 0 with flags 000, including -0 and denormals.
REQ-019 NaN (exp==31, mant!=0) gives 16'h8000 with invalid=1.
REQ-020 +Inf gives 16'h7FFF with overflow=1; -Inf gives 16'h8000 with overflow=1.
REQ-021 Normal values: magnitude = {1,mant} shifted by exp-25 (bias 15), computed in a 27-bit intermediate with 11 fraction bits kept for rounding.
REQ-022 |value| < 1 after rounding gives 0; inexact=1 if any nonzero bits were discarded.
REQ-023 Positive result > 32767 saturates to 16'h7FFF with overflow=1.
REQ-024 Negative result < -32768 saturates to 16'h8000 with overflow=1.
REQ-025 Exactly -32768.0 gives 16'h8000 with no flags.
REQ-026 On saturation, inexact=0.
REQ-027 Default rounding is toward zero.

Reset
REQ-028 rst_n low clears s1_valid and s2_valid asynchronously.
REQ-029 While rst_n is low: o_out_valid=0, o_res=16'h0000, o_flags=3'b000, o_in_ready=1.
REQ-030 Reset mid-operation discards all in-flight operands; the first post-reset result comes from the first post-reset input transfer.
REQ-031 Datapath registers other than o_res/o_flags need no reset.

Configuration
REQ-032 FP16TOINT_RNE_EN defined: round to nearest, ties to even, using the guard and sticky bits of the 11-bit fraction.
REQ-033 Rounding up may carry into saturation and then sets overflow instead of inexact.
REQ-034 FP16TOINT_RNE_EN undefined: truncation toward zero, with no rounding adder synthesized.
REQ-035 Latency and handshake are identical in both configurations.

Structure
REQ-036 Shared package fp16_pkg holds FP16_BIAS=15, FP16_EXP_W=5, FP16_MANT_W=10, FP16_EXP_SPECIAL=5'h1F, INT16_MAX=16'h7FFF, INT16_MIN=16'h8000, and a class enum {ZERO, NORMAL, INF, NAN}.
REQ-037 Sub-module fp16_classify (combinational) maps 16-bit fp16 to {sign, class, exp, mant-with-hidden-bit} under DAZ; S1 instantiates it, and the fp16 add/mul blocks reuse it.

Verification
REQ-038 1.0 and -5.0: 16'h3C00 -> o_res 16'h0001, flags 000, o_out_valid exactly 2 cycles after transfer; 16'hC500 -> 16'hFFFB, flags 000.
REQ-039 Rounding without RNE: 16'h3E00 (1.5) -> 16'h0001, inexact; 16'h4100 (2.5) -> 16'h0002, inexact.
REQ-040 Rounding with RNE: 16'h3E00 -> 16'h0002; 16'h4100 -> 16'h0002; 16'h4300 (3.5) -> 16'h0004; all inexact.
REQ-041 Specials: 16'h7800 (32768) -> 16'h7FFF, overflow; 16'hF800 -> 16'h8000, no flags; 16'h7C00 -> 16'h7FFF, overflow; 16'hFC00 -> 16'h8000, overflow; 16'h7E00 -> 16'h8000, invalid; 16'h0001 and 16'h8000 -> 16'h0000, flags 000.
REQ-042 Backpressure: i_out_ready=0 with back-to-back inputs 16'h3C00, 16'h4000, 16'h4200 -> o_in_ready falls after 2 transfers, o_res holds 16'h0001; after release, the bench sees 1, 2, 3 in order with none lost.
REQ-043 Reset mid-stream: assert rst_n low with 2 operands in flight -> o_out_valid=0 immediately (asynchronous); after release, input 16'h4400 -> 16'h0004 with no stale results.
